// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared SHA-256 widths, padder state encoding, IV and round
//               constants (also used by the compression engine).
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    localparam int BLK_W       = 512;
    localparam int WORD_W      = 32;
    localparam int LEN_FIELD_W = 64;
    localparam int BLK_WORDS   = BLK_W / WORD_W;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_FILL = 3'd1;
    localparam state_t ST_PAD  = 3'd2;
    localparam state_t ST_SEND = 3'd3;
    localparam state_t ST_WAIT = 3'd4;

    localparam logic [31:0] SHA256_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage
`default_nettype wire

// File: rtl/sha256_word_pad.sv
`default_nettype none
// ============================================================================
// Module      : sha256_word_pad
// Description : Byte mask and 0x80 marker insertion for the final message
//               word; flags when the marker spills into the next word.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_word_pad
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_data,
    input  logic [2:0]        i_bytes,
    input  logic              i_last,
    output logic [WORD_W-1:0] o_word,
    output logic [2:0]        o_nbytes,
    output logic              o_overflow
);

    // Non-final words and out-of-range counts behave as full words.
    assign o_nbytes   = (!i_last || (i_bytes > 3'd4)) ? 3'd4 : i_bytes;
    assign o_overflow = i_last && (o_nbytes == 3'd4);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        localparam logic [2:0] c_pos = 3'(gi);
        assign o_word[WORD_W-1-8*gi -: 8] =
            (c_pos < o_nbytes)  ? i_data[WORD_W-1-8*gi -: 8] :
            (c_pos == o_nbytes) ? 8'h80 : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha256_padder
// Description : Builds padded 512-bit SHA-256 blocks from a 32-bit word
//               stream. Define SHA256_PADDER_STATUS_EN for status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
)
(
    input  logic              clk_100mhz,
    input  logic              rstn_i,
    input  logic              msg_start_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              data_valid_i,
    input  logic              data_last_i,
    input  logic [2:0]        data_bytes_i,
    output logic              data_ready_o,
    input  logic              eng_ready_i,
    output logic [BLK_W-1:0]  blk_o,
    output logic              blk_start_o,
    output logic              blk_first_o,
    output logic              blk_last_o,
    output logic              busy_o
`ifdef SHA256_PADDER_STATUS_EN
    ,
    output logic [LEN_W-1:0]  msg_len_o,
    output logic [31:0]       blk_cnt_o
`endif
);

    localparam logic [WORD_W-1:0] c_marker_word = 32'h8000_0000;

    state_t                r_state;
    logic [4:0]            r_idx;
    logic [LEN_W-1:0]      r_bitlen;
    logic [WORD_W-1:0]     r_words [BLK_WORDS];
    logic                  r_first;
    logic                  r_final;
    logic                  r_pend_len;
    logic                  r_pend_80;
    logic [4:0]            r_mark_idx;
    logic                  r_mark_ovf;
    logic                  r_busy;
    logic                  r_seen_low;

    logic [WORD_W-1:0]      w_pad_word;
    logic [2:0]             w_nbytes;
    logic                   w_overflow;
    logic                   w_accept;
    logic [LEN_W-1:0]       w_add_bits;
    logic [LEN_FIELD_W-1:0] w_len_field;

    sha256_word_pad u_word_pad (
        .i_data     (data_i),
        .i_bytes    (data_bytes_i),
        .i_last     (data_last_i),
        .o_word     (w_pad_word),
        .o_nbytes   (w_nbytes),
        .o_overflow (w_overflow)
    );

    assign data_ready_o = (r_state == ST_FILL) && (r_idx < 5'd16);
    assign w_accept     = data_valid_i && data_ready_o;
    assign w_add_bits   = LEN_W'({w_nbytes, 3'b000});
    assign w_len_field  = LEN_FIELD_W'(r_bitlen);
    // Pulse is combinational so the earliest start lands two cycles after the last word.
    assign blk_start_o  = (r_state == ST_SEND) && eng_ready_i;
    assign blk_first_o  = r_first;
    assign blk_last_o   = r_final;
    assign busy_o       = r_busy;

    for (genvar gi = 0; gi < BLK_WORDS; gi++) begin : g_blk
        assign blk_o[BLK_W-1-WORD_W*gi -: WORD_W] = r_words[gi];
    end

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_bitlen   <= '0;
            r_first    <= 1'b0;
            r_final    <= 1'b0;
            r_pend_len <= 1'b0;
            r_pend_80  <= 1'b0;
            r_mark_idx <= '0;
            r_mark_ovf <= 1'b0;
            r_busy     <= 1'b0;
            r_seen_low <= 1'b0;
            for (int w = 0; w < BLK_WORDS; w++) begin
                r_words[w] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (msg_start_i) begin
                        r_idx      <= '0;
                        r_bitlen   <= '0;
                        r_first    <= 1'b1;
                        r_final    <= 1'b0;
                        r_pend_len <= 1'b0;
                        r_pend_80  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    if (w_accept) begin
                        r_words[r_idx[3:0]] <= w_pad_word;
                        r_idx               <= r_idx + 5'd1;
                        r_bitlen            <= r_bitlen + w_add_bits;
                        if (data_last_i) begin
                            r_mark_idx <= r_idx + {4'b0000, w_overflow};
                            r_mark_ovf <= w_overflow;
                            r_state    <= ST_PAD;
                        end else if (r_idx == 5'd15) begin
                            r_state <= ST_SEND;
                        end
                    end
                end

                ST_PAD: begin
                    for (int w = 0; w < BLK_WORDS; w++) begin
                        if (5'(w) > r_mark_idx) begin
                            r_words[w] <= '0;
                        end else if ((5'(w) == r_mark_idx) && r_mark_ovf) begin
                            r_words[w] <= c_marker_word;
                        end
                    end
                    if (r_mark_idx <= 5'd13) begin
                        r_words[14] <= w_len_field[63:32];
                        r_words[15] <= w_len_field[31:0];
                        r_final     <= 1'b1;
                    end else begin
                        // Length (and possibly the marker) moves to an extra block.
                        r_final    <= 1'b0;
                        r_pend_len <= 1'b1;
                        r_pend_80  <= (r_mark_idx == 5'd16);
                    end
                    r_state <= ST_SEND;
                end

                ST_SEND: begin
                    if (eng_ready_i) begin
                        r_seen_low <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (!eng_ready_i) begin
                        r_seen_low <= 1'b1;
                    end else if (r_seen_low) begin
                        r_first <= 1'b0;
                        if (r_pend_len) begin
                            for (int w = 0; w < BLK_WORDS; w++) begin
                                r_words[w] <= '0;
                            end
                            if (r_pend_80) begin
                                r_words[0] <= c_marker_word;
                            end
                            r_words[14] <= w_len_field[63:32];
                            r_words[15] <= w_len_field[31:0];
                            r_final     <= 1'b1;
                            r_pend_len  <= 1'b0;
                            r_pend_80   <= 1'b0;
                            r_state     <= ST_SEND;
                        end else if (r_final) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= '0;
                            r_state <= ST_FILL;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SHA256_PADDER_STATUS_EN
    logic [31:0] r_blk_cnt;

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            r_blk_cnt <= '0;
        end else if (blk_start_o) begin
            r_blk_cnt <= r_blk_cnt + 32'd1;
        end
    end

    assign msg_len_o = r_bitlen;
    assign blk_cnt_o = r_blk_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_padder
// Description : Self-checking bench for sha256_padder with a reference
//               padding model feeding a block scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_padder;

    typedef logic [7:0] u8_t;
    typedef struct packed {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    logic         clk_100mhz = 1'b0;
    logic         rstn_i;
    logic         msg_start_i;
    logic [31:0]  data_i;
    logic         data_valid_i;
    logic         data_last_i;
    logic [2:0]   data_bytes_i;
    logic         data_ready_o;
    logic         eng_ready_i;
    logic [511:0] blk_o;
    logic         blk_start_o;
    logic         blk_first_o;
    logic         blk_last_o;
    logic         busy_o;
`ifdef SHA256_PADDER_STATUS_EN
    logic [63:0]  msg_len_o;
    logic [31:0]  blk_cnt_o;
`endif

    int   errors = 0;
    int   checks = 0;
    int   starts = 0;
    int   exp_starts = 0;
    int   eng_busy_cycles = 3;
    bit   noisy_start = 0;
    exp_t sb[$];
    u8_t  msg[$];

    always #5 clk_100mhz = ~clk_100mhz;

    sha256_padder u_dut (
        .clk_100mhz   (clk_100mhz),
        .rstn_i       (rstn_i),
        .msg_start_i  (msg_start_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_last_i  (data_last_i),
        .data_bytes_i (data_bytes_i),
        .data_ready_o (data_ready_o),
        .eng_ready_i  (eng_ready_i),
        .blk_o        (blk_o),
        .blk_start_o  (blk_start_o),
        .blk_first_o  (blk_first_o),
        .blk_last_o   (blk_last_o),
        .busy_o       (busy_o)
`ifdef SHA256_PADDER_STATUS_EN
        ,
        .msg_len_o    (msg_len_o),
        .blk_cnt_o    (blk_cnt_o)
`endif
    );

    // Engine model: consumes each block, compares it against the scoreboard.
    initial begin : engine
        exp_t         e;
        logic [513:0] snap;
        bit           stable;
        eng_ready_i = 1'b1;
        forever begin
            @(negedge clk_100mhz);
            if (rstn_i === 1'b1 && blk_start_o === 1'b1) begin
                starts++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL blk_unexpected: got block %h, required no block", blk_o);
                end else begin
                    e = sb.pop_front();
                    if (blk_o !== e.blk) begin
                        errors++;
                        $display("FAIL blk_data: got %h required %h", blk_o, e.blk);
                    end
                    checks++;
                    if (blk_first_o !== e.first) begin
                        errors++;
                        $display("FAIL blk_first: got %b required %b", blk_first_o, e.first);
                    end
                    checks++;
                    if (blk_last_o !== e.last) begin
                        errors++;
                        $display("FAIL blk_last: got %b required %b", blk_last_o, e.last);
                    end
                end
                snap   = {blk_o, blk_first_o, blk_last_o};
                stable = 1'b1;
                @(posedge clk_100mhz);
                #1 eng_ready_i = 1'b0;
                repeat (eng_busy_cycles) begin
                    @(negedge clk_100mhz);
                    if ({blk_o, blk_first_o, blk_last_o} !== snap || blk_start_o !== 1'b0) stable = 1'b0;
                end
                eng_ready_i = 1'b1;
                checks++;
                if (!stable) begin
                    errors++;
                    $display("FAIL blk_hold: got unstable block or extra start, required stable with one start");
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic make_msg(input int len, input int seed);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(u8_t'((i * 37 + seed) & 255));
    endtask

    // Reference padding: marker, zero fill to 56 mod 64, 64-bit big-endian length.
    task automatic push_expected();
        u8_t         p[$];
        exp_t        e;
        logic [63:0] bits;
        int          nblk;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(u8_t'(bits >> (8 * k)));
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.blk = '0;
            for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = p[64*b+i];
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            sb.push_back(e);
        end
        exp_starts += nblk;
    endtask

    task automatic drive_msg(input int stop_at);
        int          nwords;
        int          lastb;
        int          guard;
        logic [31:0] d;
        nwords = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
        lastb  = msg.size() - 4 * (nwords - 1);
        msg_start_i = 1'b1;
        @(negedge clk_100mhz);
        msg_start_i = noisy_start;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b required 1", busy_o);
        end
        for (int w = 0; w < nwords; w++) begin
            for (int b = 0; b < 4; b++)
                d[31-8*b -: 8] = (4 * w + b < msg.size()) ? msg[4*w+b] : 8'hA5;
            data_i       = d;
            data_last_i  = (w == nwords - 1);
            data_bytes_i = data_last_i ? 3'(lastb) : 3'd4;
            data_valid_i = 1'b1;
            if (w == stop_at) return;
            guard = 0;
            while (data_ready_o !== 1'b1 && guard < 500) begin
                @(negedge clk_100mhz);
                guard++;
            end
            if (guard >= 500) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: got ready=%b required 1 within 500 cycles", data_ready_o);
                data_valid_i = 1'b0;
                msg_start_i  = 1'b0;
                return;
            end
            @(negedge clk_100mhz);
        end
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        msg_start_i  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while ((busy_o !== 1'b0 || sb.size() != 0) && guard < 3000) begin
            @(negedge clk_100mhz);
            guard++;
        end
        checks++;
        if (guard >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: got busy=%b pending=%0d required idle", name, busy_o, sb.size());
        end
        checks++;
        if (starts !== exp_starts) begin
            errors++;
            $display("FAIL %s_starts: got %0d required %0d", name, starts, exp_starts);
        end
    endtask

    task automatic test_reset();
        rstn_i       = 1'b0;
        msg_start_i  = 1'b0;
        data_i       = '0;
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        data_bytes_i = '0;
        repeat (3) @(negedge clk_100mhz);
        checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", data_ready_o); end
        checks++; if (blk_start_o !== 1'b0) begin errors++; $display("FAIL rst_start: got %b required 0", blk_start_o); end
        checks++; if (blk_first_o !== 1'b0) begin errors++; $display("FAIL rst_first: got %b required 0", blk_first_o); end
        checks++; if (blk_last_o !== 1'b0) begin errors++; $display("FAIL rst_last: got %b required 0", blk_last_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy_o); end
        checks++; if (blk_o !== 512'd0) begin errors++; $display("FAIL rst_blk: got %h required 0", blk_o); end
        rstn_i = 1'b1;
        @(negedge clk_100mhz);
        checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b required 0", data_ready_o); end
    endtask

    task automatic test_abc();
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        push_expected();
        drive_msg(-1);
        checks++;
        if (blk_start_o !== 1'b0) begin errors++; $display("FAIL abc_pad_cycle_start: got %b required 0", blk_start_o); end
        @(negedge clk_100mhz);
        checks++;
        if (blk_start_o !== 1'b1) begin errors++; $display("FAIL abc_latency: got start=%b required 1", blk_start_o); end
        checks++;
        if (blk_o[511:480] !== 32'h61626380 || blk_o[31:0] !== 32'h00000018)
            begin errors++; $display("FAIL abc_words: got %h/%h required 61626380/00000018", blk_o[511:480], blk_o[31:0]); end
        wait_idle("abc");
    endtask

    task automatic test_lengths();
        int lens[10] = '{0, 55, 56, 1, 4, 5, 52, 53, 60, 63};
        foreach (lens[i]) begin
            make_msg(lens[i], i * 11);
            push_expected();
            drive_msg(-1);
            wait_idle($sformatf("len%0d", lens[i]));
        end
    endtask

    task automatic test_64_stall();
        eng_busy_cycles = 10;
        make_msg(64, 5);
        push_expected();
        drive_msg(-1);
        wait_idle("len64");
        eng_busy_cycles = 3;
    endtask

    task automatic test_back_to_back();
        noisy_start = 1'b1;
        make_msg(20, 3);
        push_expected();
        drive_msg(-1);
        wait_idle("b2b_a");
        make_msg(130, 9);
        push_expected();
        drive_msg(-1);
        wait_idle("b2b_b");
        noisy_start = 1'b0;
    endtask

    task automatic test_reset_mid();
        make_msg(40, 1);
        drive_msg(7);
        #2 rstn_i = 1'b0;
        #1;
        checks++;
        if ({data_ready_o, blk_start_o, blk_first_o, blk_last_o, busy_o} !== 5'b0 || blk_o !== 512'd0)
            begin errors++; $display("FAIL mid_reset_outputs: got ready=%b busy=%b first=%b required all 0", data_ready_o, busy_o, blk_first_o); end
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        repeat (2) @(negedge clk_100mhz);
        rstn_i = 1'b1;
        @(negedge clk_100mhz);
        checks++;
        if (starts !== exp_starts) begin errors++; $display("FAIL mid_reset_starts: got %0d required %0d", starts, exp_starts); end
        test_abc();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_lengths();
        test_64_stall();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk_100mhz);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
